// File: rtl/zap_wb_arbiter.sv
// rtl/zap_wb_arbiter.sv - two-master round-robin Wishbone arbiter, optional timeout via ZAP_WB_ARB_TIMEOUT_EN
module zap_wb_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_c_wb_cyc,
    input  logic        i_c_wb_stb,
    input  logic        i_c_wb_we,
    input  logic [3:0]  i_c_wb_sel,
    input  logic [2:0]  i_c_wb_cti,
    input  logic [31:0] i_c_wb_adr,
    input  logic [31:0] i_c_wb_dat,
    output logic [31:0] o_c_wb_dat,
    output logic        o_c_wb_ack,
    output logic        o_c_wb_err,

    input  logic        i_d_wb_cyc,
    input  logic        i_d_wb_stb,
    input  logic        i_d_wb_we,
    input  logic [3:0]  i_d_wb_sel,
    input  logic [2:0]  i_d_wb_cti,
    input  logic [31:0] i_d_wb_adr,
    input  logic [31:0] i_d_wb_dat,
    output logic [31:0] o_d_wb_dat,
    output logic        o_d_wb_ack,
    output logic        o_d_wb_err,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,

    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic LAST_C = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t state_ff, state_nxt;
    logic   last_ff, last_nxt;
    logic   timeout_hit;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall_ff;

    // Stall counter: zero while idle (so every grant starts from 0), cleared on ack, counts stalled strobes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_ff <= '0;
        end else if (state_ff == IDLE || i_wb_ack) begin
            stall_ff <= '0;
        end else if (o_wb_stb && stall_ff != CW'(TIMEOUT)) begin
            stall_ff <= stall_ff + 1'b1;
        end
    end

    assign timeout_hit = (state_ff != IDLE) && (stall_ff == CW'(TIMEOUT)) && !i_wb_ack;
`else
    assign timeout_hit = 1'b0;
`endif

    // Grant state and round-robin memory; reset makes code win the first tie.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_ff <= IDLE;
            last_ff  <= LAST_D;
        end else begin
            state_ff <= state_nxt;
            last_ff  <= last_nxt;
        end
    end

    // Next-state: arbitrate only from IDLE, hold the grant for the owner's whole CYC.
    always_comb begin
        state_nxt = state_ff;
        last_nxt  = last_ff;
        case (state_ff)
            IDLE: begin
                if (i_c_wb_cyc && i_d_wb_cyc) begin
                    state_nxt = (last_ff == LAST_D) ? GNT_C : GNT_D;
                end else if (i_c_wb_cyc) begin
                    state_nxt = GNT_C;
                end else if (i_d_wb_cyc) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_C: begin
                if (timeout_hit || !i_c_wb_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = LAST_C;
                end
            end
            GNT_D: begin
                if (timeout_hit || !i_d_wb_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = LAST_D;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux: owner's request passes straight through; idle drives a quiet bus.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_sel   = 4'd0;
        o_wb_cti   = 3'd0;
        o_wb_adr   = 32'd0;
        o_wb_dat   = 32'd0;
        o_c_wb_ack = 1'b0;
        o_c_wb_err = 1'b0;
        o_d_wb_ack = 1'b0;
        o_d_wb_err = 1'b0;
        o_grant    = 2'b00;
        o_c_wb_dat = i_wb_dat;
        o_d_wb_dat = i_wb_dat;
        case (state_ff)
            GNT_C: begin
                o_wb_cyc   = i_c_wb_cyc;
                o_wb_stb   = i_c_wb_stb;
                o_wb_we    = i_c_wb_we;
                o_wb_sel   = i_c_wb_sel;
                o_wb_cti   = i_c_wb_cti;
                o_wb_adr   = i_c_wb_adr;
                o_wb_dat   = i_c_wb_dat;
                o_c_wb_ack = i_wb_ack;
                o_c_wb_err = timeout_hit;
                o_grant    = 2'b01;
            end
            GNT_D: begin
                o_wb_cyc   = i_d_wb_cyc;
                o_wb_stb   = i_d_wb_stb;
                o_wb_we    = i_d_wb_we;
                o_wb_sel   = i_d_wb_sel;
                o_wb_cti   = i_d_wb_cti;
                o_wb_adr   = i_d_wb_adr;
                o_wb_dat   = i_d_wb_dat;
                o_d_wb_ack = i_wb_ack;
                o_d_wb_err = timeout_hit;
                o_grant    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb/tb_zap_wb_arbiter.sv - directed and randomized bench for zap_wb_arbiter against an owner-level model
module tb_zap_wb_arbiter;

    localparam int TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        c_cyc, c_stb, c_we, d_cyc, d_stb, d_we;
    logic [3:0]  c_sel, d_sel;
    logic [2:0]  c_cti, d_cti;
    logic [31:0] c_adr, c_dat, d_adr, d_dat;
    logic [31:0] o_c_dat, o_d_dat;
    logic        o_c_ack, o_c_err, o_d_ack, o_d_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic [1:0]  o_grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus (0 none, 1 code, 2 data), who was served last, stalled strobes so far.
    int owner;
    int last_srv;
    int stall;

    always #5 i_clk = ~i_clk;

    zap_wb_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_c_wb_cyc(c_cyc), .i_c_wb_stb(c_stb), .i_c_wb_we(c_we), .i_c_wb_sel(c_sel),
        .i_c_wb_cti(c_cti), .i_c_wb_adr(c_adr), .i_c_wb_dat(c_dat),
        .o_c_wb_dat(o_c_dat), .o_c_wb_ack(o_c_ack), .o_c_wb_err(o_c_err),
        .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_we(d_we), .i_d_wb_sel(d_sel),
        .i_d_wb_cti(d_cti), .i_d_wb_adr(d_adr), .i_d_wb_dat(d_dat),
        .o_d_wb_dat(o_d_dat), .o_d_wb_ack(o_d_ack), .o_d_wb_err(o_d_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
        .o_wb_cti(o_wb_cti), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
        .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
        .o_grant(o_grant)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_tmo();
`ifdef ZAP_WB_ARB_TIMEOUT_EN
        return (owner != 0) && (stall == TMO) && !wb_ack;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        c_cyc = 0; c_stb = 0; c_we = 0; c_sel = 0; c_cti = 0; c_adr = 0; c_dat = 0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = 0; d_cti = 0; d_adr = 0; d_dat = 0;
        wb_ack = 0; wb_rdat = 0;
    endtask

    task automatic model_reset();
        owner = 0; last_srv = 2; stall = 0;
    endtask

    // Compare every DUT output against what the model says the bus should look like right now.
    task automatic compare_all();
        logic [73:0] eb;
        logic [3:0]  er;
        logic [1:0]  eg;
        bit          t;
        t  = model_tmo();
        eb = '0; er = '0; eg = 2'b00;
        if (owner == 1) begin
            eb = {c_cyc, c_stb, c_we, c_sel, c_cti, c_adr, c_dat};
            er = {wb_ack, t, 1'b0, 1'b0};
            eg = 2'b01;
        end else if (owner == 2) begin
            eb = {d_cyc, d_stb, d_we, d_sel, d_cti, d_adr, d_dat};
            er = {1'b0, 1'b0, wb_ack, t};
            eg = 2'b10;
        end
        check("grant", 96'(o_grant), 96'(eg));
        check("bus", 96'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_cti, o_wb_adr, o_wb_dat}), 96'(eb));
        check("resp", 96'({o_c_ack, o_c_err, o_d_ack, o_d_err}), 96'(er));
        check("rdata", 96'({o_c_dat, o_d_dat}), 96'({wb_rdat, wb_rdat}));
    endtask

    task automatic model_step();
        bit t, cx, sx;
        if (owner == 0) begin
            if (c_cyc && d_cyc) owner = (last_srv == 2) ? 1 : 2;
            else if (c_cyc)     owner = 1;
            else if (d_cyc)     owner = 2;
            stall = 0;
        end else begin
            t  = model_tmo();
            cx = (owner == 1) ? c_cyc : d_cyc;
            sx = (owner == 1) ? c_stb : d_stb;
            if (t || !cx) begin
                last_srv = owner; owner = 0; stall = 0;
            end else if (wb_ack) begin
                stall = 0;
            end else if (sx) begin
                stall++;
            end
        end
    endtask

    // Inputs are driven right after a falling edge; outputs are checked 1 time unit later.
    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    // Reset asserted between edges: outputs must fall with no clock; released on a falling edge.
    task automatic do_reset();
        i_reset_n = 0;
        #1;
        model_reset();
        check("rst_grant", 96'(o_grant), 96'(0));
        check("rst_cyc_stb", 96'({o_wb_cyc, o_wb_stb}), 96'(0));
        check("rst_resp", 96'({o_c_ack, o_c_err, o_d_ack, o_d_err}), 96'(0));
        @(posedge i_clk);
        @(negedge i_clk);
        idle_inputs();
        i_reset_n = 1;
    endtask

    initial begin
        int err_cnt, err_at, ack_pct;
        logic cyc_after;
        i_reset_n = 0;
        idle_inputs();
        model_reset();
        @(negedge i_clk);
        #1;
        check("reset_grant", 96'(o_grant), 96'(0));
        check("reset_bus", 96'({o_wb_cyc, o_wb_stb, o_wb_adr}), 96'(0));
        @(negedge i_clk);
        i_reset_n = 1;
        cycle();

        // Single code read
        c_cyc = 1; c_stb = 1; c_adr = 32'h100; c_cti = 3'b000;
        cycle();
        settle();
        check("read_adr", 96'(o_wb_adr), 96'(32'h100));
        tick();
        wb_ack = 1; wb_rdat = 32'hDEADBEEF;
        settle();
        check("read_ack", 96'({o_c_ack, o_d_ack}), 96'(2'b10));
        check("read_data", 96'(o_c_dat), 96'(32'hDEADBEEF));
        tick();
        idle_inputs();
        cycle();
        cycle();

        // Simultaneous requests after reset: code, then data, then code again
        do_reset();
        c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        settle();
        check("tie1_grant", 96'(o_grant), 96'(2'b01));
        tick();
        c_cyc = 0; c_stb = 0;
        cycle();
        settle();
        check("tie1_idle", 96'({o_grant, o_wb_cyc}), 96'(0));
        tick();
        settle();
        check("tie1_data", 96'(o_grant), 96'(2'b10));
        tick();
        d_cyc = 0; d_stb = 0;
        cycle();
        c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        settle();
        check("tie2_grant", 96'(o_grant), 96'(2'b01));
        tick();
        idle_inputs();
        cycle();
        cycle();

        // Burst lock: data 4-beat write burst while code waits
        d_cyc = 1; d_stb = 1; d_we = 1; d_cti = 3'b010; d_adr = 32'h2000;
        cycle();
        c_cyc = 1; c_stb = 1; c_adr = 32'h300;
        for (int b = 0; b < 4; b++) begin
            d_cti = (b == 3) ? 3'b111 : 3'b010;
            d_adr = 32'h2000 + 32'(b * 4);
            d_dat = $urandom;
            wb_ack = 1;
            settle();
            check("burst_grant", 96'({o_grant, o_wb_cti, o_d_ack}), 96'({2'b10, d_cti, 1'b1}));
            tick();
        end
        d_cyc = 0; d_stb = 0; wb_ack = 0;
        cycle();
        settle();
        check("burst_gap", 96'({o_grant, o_wb_cyc}), 96'(0));
        tick();
        settle();
        check("burst_next", 96'(o_grant), 96'(2'b01));
        tick();

        // Reset mid-burst: code burst, reset during beat 2
        idle_inputs();
        cycle();
        cycle();
        c_cyc = 1; c_stb = 1; c_cti = 3'b010; c_adr = 32'h400;
        cycle();
        wb_ack = 1;
        cycle();
        c_adr = 32'h404;
        settle();
        #1;
        do_reset();
        cycle();
        settle();
        check("post_rst_idle", 96'({o_grant, o_wb_cyc, o_wb_stb}), 96'(0));
        tick();

        // Timeout: code read that is never acked
        c_cyc = 1; c_stb = 1; c_adr = 32'h500;
        cycle();
        err_cnt = 0; err_at = 0; cyc_after = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            settle();
            if (o_c_err) begin
                err_cnt++;
                if (err_at == 0) err_at = k;
            end
            if (err_at != 0 && k == err_at + 1) cyc_after = o_wb_cyc;
            tick();
        end
`ifdef ZAP_WB_ARB_TIMEOUT_EN
        check("tmo_err_count", 96'(err_cnt), 96'(1));
        check("tmo_err_cycle", 96'(err_at), 96'(TMO + 1));
        check("tmo_cyc_drop", 96'(cyc_after), 96'(0));
`else
        check("tmo_no_err", 96'(err_cnt), 96'(0));
        settle();
        check("tmo_grant_held", 96'(o_grant), 96'(2'b01));
        tick();
`endif
        idle_inputs();
        cycle();
        cycle();

        // Randomized traffic against the model
        ack_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) ack_pct = $urandom_range(3, 70);
            c_cyc = c_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            d_cyc = d_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            c_stb = ($urandom_range(0, 3) != 0);
            d_stb = ($urandom_range(0, 3) != 0);
            c_we  = 1'($urandom_range(0, 1));
            d_we  = 1'($urandom_range(0, 1));
            c_sel = 4'($urandom);
            d_sel = 4'($urandom);
            c_cti = 3'($urandom);
            d_cti = 3'($urandom);
            c_adr = $urandom; c_dat = $urandom;
            d_adr = $urandom; d_dat = $urandom;
            wb_rdat = $urandom;
            wb_ack  = ($urandom_range(0, 99) < ack_pct);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zap_wb_arbiter.md
# zap_wb_arbiter

Two-master Wishbone arbiter in front of the store-FIFO adapter (`zap_wb_adapter`). It shares the single downstream Wishbone port between the instruction-side (code) and data-side masters using round-robin arbitration. A grant is locked for the whole `CYC` so bursts and multi-beat write streams are never interleaved. An optional bus-timeout watchdog aborts a hung grant and returns an error to the owning master.

## Interface
Parameters:
- `TIMEOUT`, default 256: stall cycles (`STB` high, no `ACK`) before abort; legal range 2..65535; counter width `$clog2(TIMEOUT+1)`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_c_wb_cyc`, `i_c_wb_stb`, `i_c_wb_we`  in  1 each  code master `CYC`/`STB`/`WE`.
- `i_c_wb_sel`  in  4  code byte select.
- `i_c_wb_cti`  in  3  code cycle type.
- `i_c_wb_adr`, `i_c_wb_dat`  in  32 each  code address and write data.
- `o_c_wb_dat`  out  32  read data to code master.
- `o_c_wb_ack`, `o_c_wb_err`  out  1 each  ack and error to code master.
- `i_d_wb_*` / `o_d_wb_*`: identical set for the data master.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  downstream control.
- `o_wb_sel`  out  4  downstream byte select.
- `o_wb_cti`  out  3  downstream cycle type.
- `o_wb_adr`, `o_wb_dat`  out  32 each  downstream address and write data.
- `i_wb_dat`  in  32  downstream read data.
- `i_wb_ack`  in  1  downstream ack.
- `o_grant`  out  2  one-hot owner: bit0 code, bit1 data; 0 when idle.

## Operation
- State register `state_ff` ∈ {`IDLE`, `GNT_C`, `GNT_D`}. Priority flop `last_ff` holds the last master served; reset value DATA, so code wins the first tie.
- `IDLE`:
  - All downstream outputs are 0 and both acks are 0.
  - If only one master has `CYC` high, go to that master's grant state.
  - If both have `CYC` high, grant the master that is not `last_ff`.
- `GNT_x`:
  - Downstream `cyc`/`stb`/`sel`/`cti`/`adr`/`dat`/`we` = master x inputs, combinationally.
  - `o_x_wb_ack = i_wb_ack`; the other master's ack is 0.
- Release: when `i_x_wb_cyc` = 0 in `GNT_x`, go to `IDLE` and set `last_ff` = x. Downstream `cyc` follows the master and drops in that same cycle.
- `o_c_wb_dat` = `o_d_wb_dat` = `i_wb_dat` at all times (broadcast). Masters qualify read data with their own ack.
- A master's `STB` without `CYC` is ignored.
- `o_grant` is decoded from `state_ff`.

## Timing
- Arbitration latency:
  - `CYC` rising in `IDLE` at edge N → grant state at edge N+1 → first downstream `STB` visible in cycle N+1.
  - An ack arriving in the same cycle as `STB` completes the beat.
- Turnaround: at least one `IDLE` cycle (downstream `cyc` = 0) between any two grants, including re-grant to the same master.
- Grant never changes while the owner holds `CYC`, even across `CTI`=111 end-of-burst.
- `i_wb_ack` while `IDLE` is dropped; it reaches neither master.
- Async reset assertion:
  - `state_ff` = `IDLE` and `last_ff` = DATA immediately.
  - All outputs are 0 without a clock edge, including mid-burst.
  - Deassertion is synchronised by the integrating top.

## Configuration
- Macro `ZAP_WB_ARB_TIMEOUT_EN`.
- Defined:
  - Stall counter clears on grant entry and on every `i_wb_ack`.
  - It increments each cycle in `GNT_x` with downstream `STB`=1 and `i_wb_ack`=0.
  - When the counter equals `TIMEOUT` with no ack in that cycle:
    - `o_x_wb_err` pulses for that one cycle and `o_x_wb_ack` stays 0.
    - State forced to `IDLE` at the next edge and `last_ff` = x.
    - Downstream `cyc`/`stb` are 0 from that edge.
  - The master must drop `CYC` after `ERR`. If it keeps `CYC` high, it competes normally in `IDLE`.
- Undefined: no counter logic; both `o_*_wb_err` tied to 0; a grant is held indefinitely.

## Test plan
- Single code read:
  - Stimulus: `i_c_wb_cyc`/`stb`=1, `adr`=0x100, `cti`=000; ack one cycle after `STB` appears downstream with `i_wb_dat`=0xDEADBEEF.
  - Expect: downstream `adr`=0x100 one cycle after request, `o_c_wb_ack`=1 with data 0xDEADBEEF, `o_d_wb_ack`=0 throughout.
- Simultaneous requests after reset:
  - Stimulus: both `CYC` rise at the same edge.
  - Expect: `o_grant`=01 first. After code drops `CYC`: one `IDLE` cycle, then `o_grant`=10.
  - Next simultaneous pair: expect code again (data was last served).
- Burst lock:
  - Stimulus: data 4-beat write burst (`cti` 010,010,010,111) while code holds `CYC`.
  - Expect: all 4 beats pass downstream contiguously with `o_grant`=10; code is granted only after data `CYC`=0 plus one idle cycle.
- Reset mid-burst:
  - Stimulus: assert `i_reset_n`=0 between clock edges during beat 2 of a code burst.
  - Expect: `o_wb_cyc`/`stb` and `o_grant` go to 0 before the next edge; after release, an idle bus.
- Timeout (macro defined, `TIMEOUT`=8):
  - Stimulus: code read, `i_wb_ack` held 0.
  - Expect: `o_c_wb_err`=1 for exactly one cycle, on the 9th stall cycle; downstream `cyc`=0 the next cycle.
  - Same stimulus with macro undefined: no `err`, grant held.
